vram_scan_ctrl: RTL and testbench

Display scan-out controller for the 1024-word VRAM. Runs on read_clk as the pixel clock and owns the counters for a 128x128 monochrome raster. Issues word fetches to the VRAM's dedicated fetch port with a req/ack handshake and buffers them in a 2-entry prefetch FIFO. Serialises each 16-bit word MSB-first onto a registered pixel output with hsync/vsync/active strobes.

---
 rtl/vram_scan_ctrl_pkg.sv | 25 ++
 rtl/vram_scan_ctrl_fifo.sv | 69 ++++++
 rtl/vram_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_vram_scan_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_scan_ctrl_pkg.sv
// Shared constants for the VRAM and its scan-out controller.
// The VRAM and the controller both take WORD_SIZE and the depth from here, so
// they always agree on them. The raster timing defaults also live here.
package vram_scan_ctrl_pkg;

   // VRAM geometry.
   localparam int VRAM_WORD_SIZE = 16;
   localparam int VRAM_DEPTH     = 1024;

   // Raster timing defaults: a 128x128 monochrome picture.
   localparam int SCAN_H_WORDS = 8;
   localparam int SCAN_V_LINES = 128;
   localparam int SCAN_H_BLANK = 16;
   localparam int SCAN_V_BLANK = 4;

   // Registered video strobes that leave the controller.
   typedef struct packed {
      logic pixel;
      logic active;
      logic hsync;
      logic vsync;
      logic frame_start;
   } scan_out_t;

endpackage

// File: rtl/vram_scan_ctrl_fifo.sv
// vram_prefetch_fifo: a 2-entry word FIFO that sits between the VRAM fetch
// port and the pixel shifter.
//   clk_i, reset_i  clock, asynchronous active-high reset
//   flush_i         empties the FIFO; has priority over push and pop
//   push_i          writes push_data_i; ignored when full unless a pop happens
//                   on the same edge
//   pop_i           drops the head entry; ignored when the FIFO is empty
//   count_o         number of entries held (0..2)
//   head_o          oldest entry; only meaningful when count_o != 0
module vram_prefetch_fifo
   import vram_scan_ctrl_pkg::*;
#(
   parameter int WORD_SIZE = VRAM_WORD_SIZE
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 flush_i,
   input  logic                 push_i,
   input  logic [WORD_SIZE-1:0] push_data_i,
   input  logic                 pop_i,
   output logic [1:0]           count_o,
   output logic [WORD_SIZE-1:0] head_o
);

   logic [WORD_SIZE-1:0] mem_q [2];
   logic                 rd_q, rd_d;
   logic                 wr_q, wr_d;
   logic [1:0]           count_q, count_d;
   logic                 do_push, do_pop;

   always_comb begin
      do_pop  = pop_i && (count_q != 2'd0);
      // If a pop happens on the same edge, a slot frees up, so a push is
      // still accepted when the FIFO is full.
      do_push = push_i && ((count_q != 2'd2) || do_pop);
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush_i) begin
         rd_d    = 1'b0;
         wr_d    = 1'b0;
         count_d = 2'd0;
      end else begin
         if (do_pop)  rd_d = ~rd_q;
         if (do_push) wr_d = ~wr_q;
         if (do_push && !do_pop)      count_d = count_q + 2'd1;
         else if (do_pop && !do_push) count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         count_q  <= 2'd0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         if (!flush_i && do_push) mem_q[wr_q] <= push_data_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/vram_scan_ctrl.sv
// vram_scan_ctrl: display scan-out controller for the VRAM. read_clk is the
// pixel clock. This module owns the raster counters, fetches words through the
// VRAM fetch port into a 2-entry prefetch FIFO, and shifts each word out
// MSB-first.
//   read_clk     pixel clock; all state changes on posedge
//   reset        asynchronous, active-high
//   enable       scan-out enable; when low the controller sits parked at the
//                start of vblank
//   fetch_req/fetch_addr/fetch_ack/fetch_data  word fetch port
//   pixel, active, hsync, vsync, frame_start   registered video strobes
//   underrun     sticky flag: a word was needed but the FIFO was empty
module vram_scan_ctrl
   import vram_scan_ctrl_pkg::*;
#(
   parameter int WORD_SIZE = VRAM_WORD_SIZE,
   parameter int DEPTH     = VRAM_DEPTH,
   parameter int H_WORDS   = SCAN_H_WORDS,
   parameter int V_LINES   = SCAN_V_LINES,
   parameter int H_BLANK   = SCAN_H_BLANK,
   parameter int V_BLANK   = SCAN_V_BLANK
) (
   input  logic                     read_clk,
   input  logic                     reset,
   input  logic                     enable,
   output logic                     fetch_req,
   output logic [$clog2(DEPTH)-1:0] fetch_addr,
   input  logic                     fetch_ack,
   input  logic [WORD_SIZE-1:0]     fetch_data,
   output logic                     pixel,
   output logic                     active,
   output logic                     hsync,
   output logic                     vsync,
   output logic                     frame_start,
   output logic                     underrun
);

   localparam int H_ACT   = H_WORDS * WORD_SIZE;
   localparam int H_TOTAL = H_ACT + H_BLANK;
   localparam int V_TOTAL = V_LINES + V_BLANK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int AW      = $clog2(DEPTH);
   localparam int PW      = $clog2(DEPTH + 1);
   // WORD_SIZE is a power of two, so a word boundary is where the low SW bits
   // of h are zero.
   localparam int SW      = $clog2(WORD_SIZE);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_LINES);
   localparam logic [VW-1:0] V_PRE_VB = VW'(V_LINES - 1);
   localparam logic [PW-1:0] PTR_END  = PW'(DEPTH);

   logic [HW-1:0]        h_q, h_d;
   logic [VW-1:0]        v_q, v_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [WORD_SIZE-1:0] shift_q, shift_d;
   logic                 underrun_q, underrun_d;
   logic                 run_q;
   scan_out_t            out_q, out_d;

   logic [1:0]           fifo_count;
   logic [WORD_SIZE-1:0] fifo_head;
   logic                 flush, push, pop, next_active;

   // Fetch handshake: fetch_req and fetch_addr stay stable until a cycle in
   // which fetch_ack is also high. On that edge fetch_data is captured and
   // ptr advances. An ack while fetch_req is low has no effect. run_q comes
   // out of reset asynchronously, so the request falls as soon as reset
   // rises. It rises again only after the first enabled edge.
   assign fetch_req  = run_q && enable && (fifo_count != 2'd2) && (ptr_q < PTR_END);
   assign fetch_addr = ptr_q[AW-1:0];

   always_comb begin
      h_d         = h_q;
      v_d         = v_q;
      ptr_d       = ptr_q;
      shift_d     = shift_q;
      underrun_d  = underrun_q;
      out_d       = '0;
      push        = fetch_req && fetch_ack;

      // Raster counters. While disabled, they stay parked at the start of vblank.
      if (!enable) begin
         h_d = '0;
         v_d = V_ACT_C;
      end else if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
         h_d = h_q + 1'b1;
      end

      // Entering vblank realigns the fetch stream with the frame, so any
      // damage from an underrun is confined to one frame.
      flush       = !enable || ((h_q == H_LAST) && (v_q == V_PRE_VB));
      next_active = enable && (h_d < H_ACT_C) && (v_d < V_ACT_C);
      pop         = next_active && (h_d[SW-1:0] == '0);

      if (flush)     ptr_d = '0;
      else if (push) ptr_d = ptr_q + 1'b1;

      // The shifter always holds the word for the position being entered,
      // aligned so that its MSB is the pixel for that position.
      if (!enable)          shift_d = '0;
      else if (pop)         shift_d = (fifo_count == 2'd0) ? '0 : fifo_head;
      else if (next_active) shift_d = {shift_q[WORD_SIZE-2:0], 1'b0};

      underrun_d = enable && (underrun_q || (pop && (fifo_count == 2'd0)));

      // The strobes describe the counter state before the edge.
      if (enable) begin
         out_d.active      = (h_q < H_ACT_C) && (v_q < V_ACT_C);
         out_d.pixel       = shift_q[WORD_SIZE-1] && out_d.active;
         out_d.hsync       = (h_q >= H_ACT_C);
         out_d.vsync       = (v_q >= V_ACT_C);
         out_d.frame_start = (h_q == '0) && (v_q == '0);
      end
   end

   always_ff @(posedge read_clk or posedge reset) begin
      if (reset) begin
         h_q        <= '0;
         v_q        <= V_ACT_C;
         ptr_q      <= '0;
         shift_q    <= '0;
         underrun_q <= 1'b0;
         run_q      <= 1'b0;
         out_q      <= '0;
      end else begin
         h_q        <= h_d;
         v_q        <= v_d;
         ptr_q      <= ptr_d;
         shift_q    <= shift_d;
         underrun_q <= underrun_d;
         run_q      <= enable;
         out_q      <= out_d;
      end
   end

   vram_prefetch_fifo #(
      .WORD_SIZE (WORD_SIZE)
   ) u_fifo (
      .clk_i       (read_clk),
      .reset_i     (reset),
      .flush_i     (flush),
      .push_i      (push),
      .push_data_i (fetch_data),
      .pop_i       (pop),
      .count_o     (fifo_count),
      .head_o      (fifo_head)
   );

   assign pixel       = out_q.pixel;
   assign active      = out_q.active;
   assign hsync       = out_q.hsync;
   assign vsync       = out_q.vsync;
   assign frame_start = out_q.frame_start;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_vram_scan_ctrl.sv
// Bench for vram_scan_ctrl. A VRAM responder answers the fetch port at the
// negative edge. The expected video comes from raster arithmetic: "n" counts
// enabled edges, and the strobes seen after edge n describe raster position
// (V_LINES*H_TOTAL + n - 1) mod frame size.
module tb_vram_scan_ctrl;

   localparam int H_TOTAL = 144;
   localparam int V_TOTAL = 132;
   localparam int H_ACT   = 128;
   localparam int V_LINES = 128;
   localparam int FRAME   = H_TOTAL * V_TOTAL;
   localparam int START   = V_LINES * H_TOTAL;

   logic        read_clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        fetch_ack = 1'b0;
   logic [15:0] fetch_data = 16'h0;
   logic        fetch_req;
   logic [9:0]  fetch_addr;
   logic        pixel, active, hsync, vsync, frame_start, underrun;

   int checks = 0;
   int errors = 0;

   logic [15:0] vram [1024];
   int          ack_mode = 0;   // 0 always, 1 random, 2 hold word 43 once, 3 never
   int          hold_cnt = 0;
   bit          hold_done = 0;

   vram_scan_ctrl dut (
      .read_clk    (read_clk),
      .reset       (reset),
      .enable      (enable),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ack   (fetch_ack),
      .fetch_data  (fetch_data),
      .pixel       (pixel),
      .active      (active),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   always #5 read_clk = ~read_clk;

   // VRAM fetch port model.
   always @(negedge read_clk) begin
      case (ack_mode)
         0: fetch_ack = 1'b1;
         1: fetch_ack = ($urandom_range(0, 3) != 0);
         2: begin
            if (fetch_req && fetch_addr == 10'd43 && !hold_done) begin
               if (hold_cnt >= 72) begin
                  fetch_ack = 1'b1;
                  hold_done = 1'b1;
               end else begin
                  fetch_ack = 1'b0;
                  hold_cnt++;
               end
            end else begin
               fetch_ack = 1'b1;
            end
         end
         default: fetch_ack = 1'b0;
      endcase
      fetch_data = fetch_ack ? vram[fetch_addr] : 16'($urandom);
   end

   // Reference model: {frame_start, vsync, hsync, active, pixel} after edge n.
   function automatic logic [4:0] model_out(input int n);
      int l, h, v;
      logic act, pix;
      l   = (START + n - 1) % FRAME;
      h   = l % H_TOTAL;
      v   = l / H_TOTAL;
      act = (h < H_ACT) && (v < V_LINES);
      pix = 1'b0;
      if (act) pix = vram[v * 8 + h / 16][15 - (h % 16)];
      return {(h == 0 && v == 0), (v >= V_LINES), (h >= H_ACT), act, pix};
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 1024; i++) vram[i] = 16'($urandom);
   endtask

   task automatic do_reset();
      @(negedge read_clk);
      enable = 1'b0;
      reset  = 1'b1;
      repeat (2) @(posedge read_clk);
      @(negedge read_clk);
      reset = 1'b0;
      @(negedge read_clk);
   endtask

   task automatic test_reset();
      logic [16:0] obs;
      #1 reset = 1'b1;
      #2;
      obs = {fetch_req, fetch_addr, pixel, active, hsync, vsync, frame_start, underrun};
      checks++;
      if (obs !== 17'h0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
      enable = 1'b1;
      repeat (3) @(posedge read_clk);
      #1;
      obs = {fetch_req, fetch_addr, pixel, active, hsync, vsync, frame_start, underrun};
      checks++;
      if (obs !== 17'h0) begin errors++; $display("FAIL reset_held_enabled got=%h exp=0", obs); end
      @(negedge read_clk);
      enable = 1'b0;
      reset  = 1'b0;
      repeat (2) @(posedge read_clk);
      #1;
      obs = {fetch_req, fetch_addr, pixel, active, hsync, vsync, frame_start, underrun};
      checks++;
      if (obs !== 17'h0) begin errors++; $display("FAIL disabled_outputs got=%h exp=0", obs); end
   endtask

   task automatic test_fetch_start();
      logic [4:0] obs, exp;
      int first_fs = -1;
      do_reset();
      fill_random();
      ack_mode = 0;
      @(negedge read_clk);
      enable = 1'b1;
      for (int n = 1; n <= 700; n++) begin
         @(posedge read_clk);
         #1;
         if (n == 1 || n == 2) begin
            checks++;
            if (fetch_req !== 1'b1 || fetch_addr !== 10'(n - 1)) begin
               errors++;
               $display("FAIL start_req n=%0d got req=%b addr=%0d exp req=1 addr=%0d", n, fetch_req, fetch_addr, n - 1);
            end
         end
         if (n == 3) begin
            checks++;
            if (fetch_req !== 1'b0 || fetch_addr !== 10'd2) begin
               errors++;
               $display("FAIL start_full got req=%b addr=%0d exp req=0 addr=2", fetch_req, fetch_addr);
            end
         end
         obs = {frame_start, vsync, hsync, active, pixel};
         exp = model_out(n);
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL start_video n=%0d got=%b exp=%b", n, obs, exp); end
         if (frame_start === 1'b1 && first_fs < 0) first_fs = n;
      end
      checks++;
      if (first_fs != 577) begin errors++; $display("FAIL start_frame_start_edge got=%0d exp=577", first_fs); end
   endtask

   task automatic test_word_pattern();
      logic [4:0]  obs, exp;
      logic [15:0] pix16 = 16'h0;
      int act_cnt = 0, hs_cnt = 0;
      do_reset();
      fill_random();
      vram[0]  = 16'hA000;
      ack_mode = 0;
      @(negedge read_clk);
      enable = 1'b1;
      for (int n = 1; n <= 577 + 2 * H_TOTAL; n++) begin
         @(posedge read_clk);
         #1;
         if (n >= 577 && n < 593) pix16[15 - (n - 577)] = pixel;
         if (n >= 577 && n < 577 + H_TOTAL) begin
            act_cnt += int'(active);
            hs_cnt  += int'(hsync);
         end
         obs = {frame_start, vsync, hsync, active, pixel};
         exp = model_out(n);
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL pattern_video n=%0d got=%b exp=%b", n, obs, exp); end
      end
      checks++;
      if (pix16 !== 16'hA000) begin errors++; $display("FAIL pattern_first_word got=%h exp=a000", pix16); end
      checks++;
      if (act_cnt != 128 || hs_cnt != 16) begin
         errors++;
         $display("FAIL pattern_line_split got active=%0d hsync=%0d exp active=128 hsync=16", act_cnt, hs_cnt);
      end
   endtask

   task automatic test_checkerboard();
      logic [4:0] obs, exp;
      do_reset();
      for (int i = 0; i < 1024; i++) vram[i] = ((i / 8) % 2 == 0) ? 16'hAAAA : 16'h5555;
      ack_mode = 1;
      @(negedge read_clk);
      enable = 1'b1;
      for (int n = 1; n <= 577 + FRAME; n++) begin
         @(posedge read_clk);
         #1;
         obs = {frame_start, vsync, hsync, active, pixel};
         exp = model_out(n);
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL checker_video n=%0d got=%b exp=%b", n, obs, exp); end
         checks++;
         if (underrun !== 1'b0) begin errors++; $display("FAIL checker_underrun n=%0d got=%b exp=0", n, underrun); end
         // Last pop of the frame is done by here and ptr has reached DEPTH.
         if (n >= 18984 && n <= 19007) begin
            checks++;
            if (fetch_req !== 1'b0) begin errors++; $display("FAIL checker_req_end n=%0d got=%b exp=0", n, fetch_req); end
         end
         if (n == 19008) begin
            checks++;
            if (fetch_req !== 1'b1 || fetch_addr !== 10'd0) begin
               errors++;
               $display("FAIL checker_flush got req=%b addr=%0d exp req=1 addr=0", fetch_req, fetch_addr);
            end
         end
      end
   endtask

   task automatic test_underrun();
      logic [4:0] obs, exp;
      localparam int DAMAGE = 577 + 5 * H_TOTAL + 48;
      do_reset();
      fill_random();
      hold_cnt  = 0;
      hold_done = 0;
      ack_mode  = 2;
      @(negedge read_clk);
      enable = 1'b1;
      for (int n = 1; n <= 577 + FRAME + 1600; n++) begin
         @(posedge read_clk);
         #1;
         obs = {frame_start, vsync, hsync, active, pixel};
         exp = model_out(n);
         if (n < DAMAGE || n >= 577 + START) begin
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL underrun_video n=%0d got=%b exp=%b", n, obs, exp); end
         end else if (n < DAMAGE + 16) begin
            checks++;
            if (pixel !== 1'b0) begin errors++; $display("FAIL underrun_zero_word n=%0d got=%b exp=0", n, pixel); end
         end
         checks++;
         if (underrun !== (n >= DAMAGE - 1)) begin
            errors++;
            $display("FAIL underrun_flag n=%0d got=%b exp=%b", n, underrun, (n >= DAMAGE - 1));
         end
      end
      ack_mode = 0;
   endtask

   task automatic test_reset_midfetch();
      logic [4:0]  obs, exp;
      logic [16:0] all;
      int n = 0, first_fs = -1;
      bit found = 0;
      do_reset();
      fill_random();
      ack_mode = 0;
      @(negedge read_clk);
      enable = 1'b1;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(posedge read_clk);
         n++;
         @(negedge read_clk);
         #1;
         if (n > 900 && fetch_req === 1'b1 && fetch_ack === 1'b1) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL midfetch_find got=0 exp=1"); end
      reset = 1'b1;
      #1;
      all = {fetch_req, fetch_addr, pixel, active, hsync, vsync, frame_start, underrun};
      checks++;
      if (all !== 17'h0) begin errors++; $display("FAIL midfetch_async got=%h exp=0", all); end
      @(posedge read_clk);
      #1;
      all = {fetch_req, fetch_addr, pixel, active, hsync, vsync, frame_start, underrun};
      checks++;
      if (all !== 17'h0) begin errors++; $display("FAIL midfetch_ack_ignored got=%h exp=0", all); end
      enable = 1'b0;
      @(negedge read_clk);
      reset = 1'b0;
      @(negedge read_clk);
      enable = 1'b1;
      for (int k = 1; k <= 600; k++) begin
         @(posedge read_clk);
         #1;
         if (k == 1) begin
            checks++;
            if (fetch_req !== 1'b1 || fetch_addr !== 10'd0) begin
               errors++;
               $display("FAIL midfetch_restart_req got req=%b addr=%0d exp req=1 addr=0", fetch_req, fetch_addr);
            end
         end
         obs = {frame_start, vsync, hsync, active, pixel};
         exp = model_out(k);
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL midfetch_video k=%0d got=%b exp=%b", k, obs, exp); end
         if (frame_start === 1'b1 && first_fs < 0) first_fs = k;
      end
      checks++;
      if (first_fs != 577) begin errors++; $display("FAIL midfetch_frame_start got=%0d exp=577", first_fs); end
   endtask

   task automatic test_enable_drop();
      logic [4:0] obs, exp;
      logic [5:0] all;
      int first_fs = -1;
      do_reset();
      fill_random();
      ack_mode = 3;
      @(negedge read_clk);
      enable = 1'b1;
      for (int n = 1; n <= 577 + 60 * H_TOTAL + 10; n++) begin
         @(posedge read_clk);
         #1;
         obs = {frame_start, vsync, hsync, active, pixel};
         exp = model_out(n);
         exp[0] = 1'b0;   // nothing is ever delivered, so every pixel is dark
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL drop_starved_video n=%0d got=%b exp=%b", n, obs, exp); end
      end
      checks++;
      if (underrun !== 1'b1) begin errors++; $display("FAIL drop_underrun_before got=%b exp=1", underrun); end
      @(negedge read_clk);
      enable = 1'b0;
      #1;
      checks++;
      if (fetch_req !== 1'b0) begin errors++; $display("FAIL drop_req_immediate got=%b exp=0", fetch_req); end
      @(posedge read_clk);
      #1;
      all = {pixel, active, hsync, vsync, frame_start, underrun};
      checks++;
      if (all !== 6'h0) begin errors++; $display("FAIL drop_outputs got=%b exp=000000", all); end
      ack_mode = 0;
      @(negedge read_clk);
      enable = 1'b1;
      for (int k = 1; k <= 577 + 2 * H_TOTAL; k++) begin
         @(posedge read_clk);
         #1;
         obs = {frame_start, vsync, hsync, active, pixel};
         exp = model_out(k);
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL drop_resume_video k=%0d got=%b exp=%b", k, obs, exp); end
         checks++;
         if (underrun !== 1'b0) begin errors++; $display("FAIL drop_resume_underrun k=%0d got=%b exp=0", k, underrun); end
         if (frame_start === 1'b1 && first_fs < 0) first_fs = k;
      end
      checks++;
      if (first_fs != 577) begin errors++; $display("FAIL drop_frame_start got=%0d exp=577", first_fs); end
   endtask

   initial begin
      test_reset();
      test_fetch_start();
      test_word_pattern();
      test_checkerboard();
      test_underrun();
      test_reset_midfetch();
      test_enable_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
